// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchronizer plus debounce FSM driving registered level/press/release outputs.
// Defining BTN_DEBOUNCE_AUTO_REPEAT_EN adds auto-repeat press pulses while the button is held.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_DELAY    = 50000,
  parameter int REPEAT_PERIOD   = 10000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic level_out,
  output logic press_pulse,
  output logic release_pulse
);
  localparam int MAX_DR = DEBOUNCE_CYCLES > REPEAT_DELAY ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_ALL = MAX_DR > REPEAT_PERIOD ? MAX_DR : REPEAT_PERIOD;
  localparam int W = $clog2(MAX_ALL) + 1;
  localparam logic [W-1:0] DC = W'(DEBOUNCE_CYCLES);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
  state_t state_q, state_d;
  logic s1_q, s2_q;
  logic [W-1:0] cnt_q, cnt_d;
  logic level_q, level_d, press_q, press_d, release_q, release_d;
  logic done, waiting, rep_fire;
  // cnt_q counts stable samples before this one, so the current sample completes the run at cnt_q + 1
  assign done = cnt_q + W'(1) >= DC;
  always_comb begin
    state_d = level_q ? (s2_q ? HELD : done ? IDLE : RELEASE_WAIT)
                      : (s2_q ? (done ? HELD : PRESS_WAIT) : IDLE);
    level_d = state_d == HELD || state_d == RELEASE_WAIT;
    waiting = state_d == PRESS_WAIT || state_d == RELEASE_WAIT;
    cnt_d = !waiting ? '0 : state_d != state_q ? W'(1) : &cnt_q ? cnt_q : cnt_q + W'(1);
    press_d = (!level_q && level_d) || rep_fire;
    release_d = level_q && !level_d;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      state_q <= IDLE;
      cnt_q <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q <= btn_in;
      s2_q <= s1_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      release_q <= release_d;
    end
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
  localparam logic [W-1:0] RD = W'(REPEAT_DELAY);
  localparam logic [W-1:0] RP = W'(REPEAT_PERIOD);
  logic [W-1:0] rep_q, rep_d;
  logic first_q, first_d, stay, clr;
  // rep_q counts HELD cycles since acceptance or the last repeat; RELEASE_WAIT leaves it frozen
  always_comb begin
    stay = state_q == HELD && state_d == HELD;
    clr = !level_q || !level_d;
    rep_fire = stay && rep_q + W'(1) == (first_q ? RD : RP);
    rep_d = clr || rep_fire ? '0 : stay ? rep_q + W'(1) : rep_q;
    first_d = clr ? 1'b1 : rep_fire ? 1'b0 : first_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rep_q <= '0;
      first_q <= 1'b1;
    end else begin
      rep_q <= rep_d;
      first_q <= first_d;
    end
`else
  assign rep_fire = 1'b0;
`endif
  assign level_out = level_q;
  assign press_pulse = press_q;
  assign release_pulse = release_q;
endmodule
